// File: rtl/pmm_pkg.sv
// Shared types and helpers for the pair-match monitor: state encoding,
// compare-mode constants and a saturating increment.
package pmm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MATCHED = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_EXACT = 2'd0;
  localparam logic [1:0] MODE_SWAP  = 2'd1;
  localparam logic [1:0] MODE_MSB   = 2'd2;

  localparam int unsigned SAT_W = 32;

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pair_cmp.sv
// Combinational operand-pair comparator; mode 3 falls back to exact compare.
module pair_cmp
  import pmm_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] t1,
  input  logic [WIDTH-1:0] t2,
  input  logic [1:0]       mode,
  output logic             hit
);

  logic exact;
  logic swapped;
  logic msb_eq;

  always_comb begin
    exact   = (num1 == t1) && (num2 == t2);
    swapped = (num1 == t2) && (num2 == t1);
    msb_eq  = (num1[WIDTH-1] == t1[WIDTH-1]) && (num2[WIDTH-1] == t2[WIDTH-1]);
    hit     = exact;
    case (mode)
      MODE_SWAP: hit = exact || swapped;
      MODE_MSB:  hit = msb_eq;
      default:   hit = exact;
    endcase
  end

endmodule

// File: rtl/pair_match_monitor.sv
// Watches an operand-pair stream against a latched target and reports a sticky
// MATCH after HOLD consecutive hits, or TIMEOUT when the window runs out.
module pair_match_monitor
  import pmm_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] window,
  input  logic             valid,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [WIDTH-1:0] a_num1,
  input  logic [WIDTH-1:0] a_num2,
  output logic             busy,
  output logic             match,
  output logic             timeout,
  output logic [CNT_W-1:0] hit_count,
  output logic [1:0]       state_o
);

  // HOLD is limited to 1..15, so the run counter never needs more than 4 bits.
  localparam int unsigned RUN_W   = 4;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] t1_q,        t1_d;
  logic [WIDTH-1:0] t2_q,        t2_d;
  logic [1:0]       mode_q,      mode_d;
  logic [CNT_W-1:0] window_q,    window_d;
  logic [RUN_W-1:0] run_q,       run_d;
  logic [CNT_W-1:0] elapsed_q,   elapsed_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             busy_q,      busy_d;
  logic             match_q,     match_d;
  logic             timeout_q,   timeout_d;

  logic             cmp_hit;
  logic             hit;
  logic [CNT_W-1:0] elapsed_inc;
  logic [CNT_W-1:0] hit_count_inc;
  logic [RUN_W-1:0] run_inc;

  pair_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .num1 (num1),
    .num2 (num2),
    .t1   (t1_q),
    .t2   (t2_q),
    .mode (mode_q),
    .hit  (cmp_hit)
  );

  assign hit = valid && cmp_hit;

  always_comb begin
    state_d       = state_q;
    t1_d          = t1_q;
    t2_d          = t2_q;
    mode_d        = mode_q;
    window_d      = window_q;
    run_d         = run_q;
    elapsed_d     = elapsed_q;
    hit_count_d   = hit_count_q;
    elapsed_inc   = CNT_W'(sat_inc(32'(elapsed_q), CNT_MAX));
    hit_count_inc = CNT_W'(sat_inc(32'(hit_count_q), CNT_MAX));
    run_inc       = RUN_W'(run_q + RUN_W'(1));

    if (clear) begin
      state_d     = ST_IDLE;
      run_d       = '0;
      elapsed_d   = '0;
      hit_count_d = '0;
    end else if (start) begin
      // Arming (or re-arming) latches the target; no compare on this cycle.
      state_d     = ST_ARMED;
      t1_d        = a_num1;
      t2_d        = a_num2;
      mode_d      = mode;
      window_d    = window;
      run_d       = '0;
      elapsed_d   = '0;
      hit_count_d = '0;
    end else if (state_q == ST_ARMED) begin
      elapsed_d = elapsed_inc;
      if (hit) begin
        run_d       = run_inc;
        hit_count_d = hit_count_inc;
      end else begin
        run_d = '0;
      end
      // A HOLD-th hit on the expiry cycle still counts as a match.
      if (hit && (run_inc == RUN_W'(HOLD))) begin
        state_d = ST_MATCHED;
      end else if ((window_q != '0) && (elapsed_inc == window_q)) begin
        state_d = ST_TIMEOUT;
      end
    end

    busy_d    = (state_d == ST_ARMED);
    match_d   = (state_d == ST_MATCHED);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      t1_q        <= '0;
      t2_q        <= '0;
      mode_q      <= '0;
      window_q    <= '0;
      run_q       <= '0;
      elapsed_q   <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      mode_q      <= mode_d;
      window_q    <= window_d;
      run_q       <= run_d;
      elapsed_q   <= elapsed_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
      match_q     <= match_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy      = busy_q;
  assign match     = match_q;
  assign timeout   = timeout_q;
  assign hit_count = hit_count_q;
  assign state_o   = state_q;

endmodule
